// File: rtl/rr_arbiter_2x4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface rr_arbiter_2x4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  modport master (output req, input gnt, gnt_id, gnt_valid);
  modport slave  (input req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/rr_arbiter_2x4.sv
// Four-way round-robin arbiter with bounded hold time. All outputs come from
// registered state, so there is no combinational path from req to any output.
module rr_arbiter_2x4 #(
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  rr_arbiter_2x4_if.slave  bus
);
  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [1:0] gnt_id, gnt_id_nx;
  logic [1:0] ptr, ptr_nx;
  logic [3:0] hold_cnt, hold_nx;

  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic       keep;

  // Search ptr, ptr+1, ... ptr+3; ptr already points past the last owner,
  // so the current owner is naturally considered last.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign keep = (state == GRANT) && bus.req[gnt_id] && (hold_cnt < 4'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_id   <= 2'd0;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      gnt_id   <= gnt_id_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    gnt_id_nx = gnt_id;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    if (keep) begin
      hold_nx = hold_cnt + 4'd1;
    end else if (found) begin
      // Back-to-back hand-off (or owner re-winning after an expired hold).
      state_nx  = GRANT;
      gnt_id_nx = win;
      ptr_nx    = win + 2'd1;
      hold_nx   = 4'd1;
    end else begin
      state_nx = IDLE;
      hold_nx  = 4'd0;
    end
  end

  assign bus.gnt_valid = (state == GRANT);
  assign bus.gnt_id    = gnt_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dec
    assign bus.gnt[g] = (state == GRANT) && (gnt_id == 2'(g));
  end
endmodule
